// File: rtl/adder_pkg.sv
// Shared widths and types for the half_adder result path.
package adder_pkg;

   localparam int OPND_W = 9;
   localparam int SUM_W  = 10;
   localparam int ACC_W  = 16;

   typedef logic [SUM_W-1:0] sum_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO for adder_result_sink: storage, wrapping pointers and a
// separate occupancy count with registered full/empty flags.
module result_fifo
   import adder_pkg::*;
#(
   parameter int DATA_W = SUM_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] head,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // NOTE: storage is deliberately not reset; count and pointers alone decide
   // which words are valid, and the head is gated to 0 when empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   assign head  = empty_q ? '0 : mem[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/adder_result_sink.sv
// Receive buffer for the half_adder result stream: drop-on-full capture with a
// sticky overflow flag; optional saturating accumulator under RESULT_SINK_ACC_EN.
module adder_result_sink
   import adder_pkg::*;
#(
   parameter int DATA_W = SUM_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   input  logic              clr_ovf,
`ifdef RESULT_SINK_ACC_EN
   output logic [ACC_W-1:0]  acc_sum,
   output logic              acc_sat,
`endif
   output logic              overflow
);

   logic push;
   logic pop;
   logic drop;
   logic fifo_full;
   logic fifo_empty;
   logic overflow_q, overflow_d;

   result_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (data_in),
      .head  (data_out),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a beat.
   always_comb begin
      out_valid  = !fifo_empty;
      pop        = out_valid && out_ready;
      push       = in_valid && (!fifo_full || pop);
      drop       = in_valid && fifo_full && !pop;
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign full     = fifo_full;
   assign empty    = fifo_empty;
   assign overflow = overflow_q;

`ifdef RESULT_SINK_ACC_EN
   localparam int EXT_W = ((DATA_W > ACC_W) ? DATA_W : ACC_W) + 1;
   localparam logic [EXT_W-1:0] ACC_MAX = EXT_W'({ACC_W{1'b1}});

   logic [EXT_W-1:0] acc_ext;
   logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
   logic             acc_sat_q, acc_sat_d;

   always_comb begin
      acc_sum_d = acc_sum_q;
      acc_sat_d = acc_sat_q;
      acc_ext   = EXT_W'(acc_sum_q) + EXT_W'(data_in);
      if (push) begin
         if (acc_ext > ACC_MAX) begin
            acc_sum_d = {ACC_W{1'b1}};
            acc_sat_d = 1'b1;
         end else begin
            acc_sum_d = acc_ext[ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_sum_q <= '0;
         acc_sat_q <= 1'b0;
      end else begin
         acc_sum_q <= acc_sum_d;
         acc_sat_q <= acc_sat_d;
      end
   end

   assign acc_sum = acc_sum_q;
   assign acc_sat = acc_sat_q;
`endif

endmodule

// File: tb/tb_adder_result_sink.sv
// Self-checking bench for adder_result_sink: directed vector table, then
// random traffic compared against a queue-based reference model.
module tb_adder_result_sink;
   import adder_pkg::*;

   localparam int DATA_W = SUM_W;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int ACC_MAX = (1 << ACC_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              clr_ovf = 1'b0;
   logic              overflow;
`ifdef RESULT_SINK_ACC_EN
   logic [ACC_W-1:0]  acc_sum;
   logic              acc_sat;
`endif

   adder_result_sink #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .clr_ovf   (clr_ovf),
`ifdef RESULT_SINK_ACC_EN
      .acc_sum   (acc_sum),
      .acc_sat   (acc_sat),
`endif
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: contents in arrival order plus flags.
   int q[$];
   bit m_ovf = 1'b0;
   int m_acc = 0;
   bit m_sat = 1'b0;

   typedef struct {
      bit        r;
      bit        iv;
      int        di;
      bit        ordy;
      bit        cl;
      int        e_count;
      int        e_data;
      bit        e_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input bit r, input bit iv, input int di, input bit ordy, input bit cl,
                      input int ec, input int ed, input bit eo);
      vec_t v;
      v.r = r; v.iv = iv; v.di = di; v.ordy = ordy; v.cl = cl;
      v.e_count = ec; v.e_data = ed; v.e_ovf = eo;
      vecs.push_back(v);
   endtask

   task automatic model_step(input bit r, input bit iv, input int di, input bit ordy, input bit cl);
      bit do_pop;
      bit is_full;
      if (r) begin
         q.delete();
         m_ovf = 1'b0;
         m_acc = 0;
         m_sat = 1'b0;
      end else begin
         do_pop  = (q.size() > 0) && ordy;
         is_full = (q.size() == DEPTH);
         if (iv && is_full && !do_pop) begin
            m_ovf = 1'b1;
         end else begin
            if (cl) m_ovf = 1'b0;
            if (do_pop) void'(q.pop_front());
            if (iv) begin
               q.push_back(di);
               if (m_acc + di > ACC_MAX) begin
                  m_acc = ACC_MAX;
                  m_sat = 1'b1;
               end else begin
                  m_acc = m_acc + di;
               end
            end
         end
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare #1 after the edge.
   task automatic cycle(input bit r, input bit iv, input int di, input bit ordy, input bit cl);
      rst       = r;
      in_valid  = iv;
      data_in   = DATA_W'(di);
      out_ready = ordy;
      clr_ovf   = cl;
      @(posedge clk);
      #1;
      model_step(r, iv, di, ordy, cl);
      check("model_count", 32'(count), 32'(q.size()));
      check("model_data_out", 32'(data_out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
      check("model_out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("model_full", 32'(full), 32'(q.size() == DEPTH));
      check("model_empty", 32'(empty), 32'(q.size() == 0));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
`ifdef RESULT_SINK_ACC_EN
      check("model_acc_sum", 32'(acc_sum), 32'(m_acc));
      check("model_acc_sat", 32'(acc_sat), 32'(m_sat));
`endif
   endtask

   initial begin
      // Directed sequence; expectations are the state right after each edge.
      add(1, 0,  0, 0, 0,  0,  0, 0);  // reset
      add(0, 1, 71, 1, 0,  1, 71, 0);  // 71 visible one edge after push
      add(0, 1, 61, 1, 0,  1, 61, 0);  // 71 popped, 61 pushed
      add(0, 0,  0, 1, 0,  0,  0, 0);
      add(0, 1, 71, 0, 0,  1, 71, 0);  // fill with out_ready low
      add(0, 1, 61, 0, 0,  2, 71, 0);
      add(0, 1, 56, 0, 0,  3, 71, 0);
      add(0, 1, 15, 0, 0,  4, 71, 0);
      add(0, 1, 99, 0, 0,  4, 71, 1);  // dropped
      add(0, 0,  0, 0, 1,  4, 71, 0);  // clr_ovf
      add(0, 1, 42, 1, 0,  4, 61, 0);  // push+pop while full
      add(0, 0,  0, 1, 0,  3, 56, 0);
      add(0, 0,  0, 1, 0,  2, 15, 0);
      add(0, 0,  0, 1, 0,  1, 42, 0);
      add(0, 0,  0, 1, 0,  0,  0, 0);
      add(0, 1,  1, 0, 0,  1,  1, 0);
      add(0, 1,  2, 0, 0,  2,  1, 0);
      add(0, 1,  3, 0, 0,  3,  1, 0);
      add(0, 1,  4, 0, 0,  4,  1, 0);
      add(0, 1,  5, 0, 1,  4,  1, 1);  // drop beats simultaneous clr_ovf
      add(0, 0,  0, 1, 0,  3,  2, 1);
      add(1, 1,  7, 1, 0,  0,  0, 0);  // reset with 3 buffered, in_valid ignored
      add(0, 0,  0, 0, 0,  0,  0, 0);

      foreach (vecs[i]) begin
         cycle(vecs[i].r, vecs[i].iv, vecs[i].di, vecs[i].ordy, vecs[i].cl);
         check("vec_count", 32'(count), 32'(vecs[i].e_count));
         check("vec_data_out", 32'(data_out), 32'(vecs[i].e_data));
         check("vec_overflow", 32'(overflow), 32'(vecs[i].e_ovf));
         check("vec_full", 32'(full), 32'(vecs[i].e_count == DEPTH));
         check("vec_empty", 32'(empty), 32'(vecs[i].e_count == 0));
         check("vec_out_valid", 32'(out_valid), 32'(vecs[i].e_count != 0));
`ifdef RESULT_SINK_ACC_EN
         if (i == 2) check("acc_71_61", 32'(acc_sum), 32'd132);
`endif
      end

`ifdef RESULT_SINK_ACC_EN
      cycle(1, 0, 0, 0, 0);
      for (int k = 0; k < 70; k++) cycle(0, 1, 1023, 1, 0);
      check("acc_saturated", 32'(acc_sum), 32'd65535);
      check("acc_sat_flag", 32'(acc_sat), 32'd1);
      cycle(0, 0, 0, 1, 1);
      check("acc_sat_after_clr", 32'(acc_sat), 32'd1);
`endif

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 9) < 7),
               int'($urandom_range(0, (1 << DATA_W) - 1)),
               ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 19) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
